// File: rtl/regfile_sb.sv
// regfile_sb: MIPS32 general-purpose register file with byte-enabled writes,
// an optional hardwired zero register, write-to-read bypass and a per-register
// busy scoreboard whose population count is kept in a register.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                RegWrite,
  input  logic [ADDR_W-1:0]   WriteAddr,
  input  logic [DATA_W-1:0]   WriteData,
  input  logic [DATA_W/8-1:0] WriteByteEn,
  input  logic [ADDR_W-1:0]   ReadAddr1,
  input  logic [ADDR_W-1:0]   ReadAddr2,
  output logic [DATA_W-1:0]   ReadData1,
  output logic [DATA_W-1:0]   ReadData2,
  output logic                ReadBusy1,
  output logic                ReadBusy2,
  input  logic                SetBusy,
  input  logic [ADDR_W-1:0]   SetBusyAddr,
  output logic [ADDR_W:0]     PendingCount
);

  localparam int DEPTH   = 1 << ADDR_W;
  localparam int NB      = DATA_W / 8;
  localparam bit ZERO_EN = (ZERO_REG != 0);
  localparam bit BYP_EN  = (BYPASS != 0);

  // Overlay the enabled bytes of new_v onto old_v.
  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_v,
    input logic [DATA_W-1:0] new_v,
    input logic [NB-1:0]     be
  );
    logic [DATA_W-1:0] res;
    res = old_v;
    for (int i = 0; i < NB; i++) begin
      res[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return res;
  endfunction

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_d;

  logic              wr_en_s;
  logic              set_en_s;
  logic              set_new_s;
  logic              clr_eff_s;
  logic [DATA_W-1:0] wr_word_s;

  // Qualify the write and set strobes (register 0 is inert when hardwired).
  always_comb begin
    wr_en_s   = RegWrite & ~(ZERO_EN & (WriteAddr == {ADDR_W{1'b0}}));
    set_en_s  = SetBusy & ~(ZERO_EN & (SetBusyAddr == {ADDR_W{1'b0}}));
    wr_word_s = merge_bytes(regs_q[WriteAddr], WriteData, WriteByteEn);
  end

  // Next busy vector and count: clear first, then set, so a new producer wins.
  always_comb begin
    busy_d              = busy_q;
    busy_d[WriteAddr]   = wr_en_s ? 1'b0 : busy_q[WriteAddr];
    busy_d[SetBusyAddr] = set_en_s ? 1'b1 : busy_d[SetBusyAddr];
    // Only edges of a busy bit move the count, so re-sets never double count.
    set_new_s = set_en_s & ~busy_q[SetBusyAddr];
    clr_eff_s = wr_en_s & busy_q[WriteAddr]
              & ~(set_en_s & (SetBusyAddr == WriteAddr));
    count_d   = count_q + {{ADDR_W{1'b0}}, set_new_s}
                        - {{ADDR_W{1'b0}}, clr_eff_s};
  end

  // Register storage: byte-merged write of the addressed register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_en_s) begin
      regs_q[WriteAddr] <= wr_word_s;
    end
  end

  // Scoreboard state: busy bits and their registered population count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= {DEPTH{1'b0}};
      count_q <= {(ADDR_W+1){1'b0}};
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  // Read ports: zero register, then same-cycle bypass, then stored value.
  always_comb begin
    if (ZERO_EN && (ReadAddr1 == {ADDR_W{1'b0}})) begin
      ReadData1 = {DATA_W{1'b0}};
    end else if (BYP_EN && RegWrite && (WriteAddr == ReadAddr1)) begin
      ReadData1 = merge_bytes(regs_q[ReadAddr1], WriteData, WriteByteEn);
    end else begin
      ReadData1 = regs_q[ReadAddr1];
    end
    if (ZERO_EN && (ReadAddr2 == {ADDR_W{1'b0}})) begin
      ReadData2 = {DATA_W{1'b0}};
    end else if (BYP_EN && RegWrite && (WriteAddr == ReadAddr2)) begin
      ReadData2 = merge_bytes(regs_q[ReadAddr2], WriteData, WriteByteEn);
    end else begin
      ReadData2 = regs_q[ReadAddr2];
    end
  end

  // Busy flags seen by issue: a retiring write hides busy unless re-claimed.
  always_comb begin
    ReadBusy1 = busy_q[ReadAddr1]
              & ~(BYP_EN & RegWrite & (WriteAddr == ReadAddr1)
                  & ~(set_en_s & (SetBusyAddr == ReadAddr1)));
    ReadBusy2 = busy_q[ReadAddr2]
              & ~(BYP_EN & RegWrite & (WriteAddr == ReadAddr2)
                  & ~(set_en_s & (SetBusyAddr == ReadAddr2)));
  end

  assign PendingCount = count_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: the default instance (BYPASS=1, ZERO_REG=1)
// and a second instance (BYPASS=0, ZERO_REG=0) share all stimulus.
module tb_regfile_sb;

  logic        clk;
  logic        rst_n;
  logic        RegWrite;
  logic [4:0]  WriteAddr;
  logic [31:0] WriteData;
  logic [3:0]  WriteByteEn;
  logic [4:0]  ReadAddr1;
  logic [4:0]  ReadAddr2;
  logic        SetBusy;
  logic [4:0]  SetBusyAddr;

  logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
  logic        rb1_a, rb2_a, rb1_b, rb2_b;
  logic [5:0]  cnt_a, cnt_b;

  int checks;
  int errors;

  regfile_sb u_dut (
    .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite), .WriteAddr(WriteAddr),
    .WriteData(WriteData), .WriteByteEn(WriteByteEn),
    .ReadAddr1(ReadAddr1), .ReadAddr2(ReadAddr2),
    .ReadData1(rd1_a), .ReadData2(rd2_a),
    .ReadBusy1(rb1_a), .ReadBusy2(rb2_a),
    .SetBusy(SetBusy), .SetBusyAddr(SetBusyAddr), .PendingCount(cnt_a)
  );

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite), .WriteAddr(WriteAddr),
    .WriteData(WriteData), .WriteByteEn(WriteByteEn),
    .ReadAddr1(ReadAddr1), .ReadAddr2(ReadAddr2),
    .ReadData1(rd1_b), .ReadData2(rd2_b),
    .ReadBusy1(rb1_b), .ReadBusy2(rb2_b),
    .SetBusy(SetBusy), .SetBusyAddr(SetBusyAddr), .PendingCount(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    RegWrite    = 1'b0;
    SetBusy     = 1'b0;
    WriteByteEn = 4'h0;
  endtask

  // Apply the current inputs over one posedge, then land 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(posedge clk); #1;
    RegWrite = 1'b1; WriteAddr = 5'd3; WriteData = 32'hDEADBEEF; WriteByteEn = 4'hF;
    SetBusy = 1'b1; SetBusyAddr = 5'd3; ReadAddr1 = 5'd3; ReadAddr2 = 5'd3;
    step();
    idle(); #1;
    checks++; if (rd1_a !== 32'hDEADBEEF) begin errors++; $display("FAIL reset_preload_data got %h exp %h", rd1_a, 32'hDEADBEEF); end
    checks++; if (rb1_a !== 1'b1) begin errors++; $display("FAIL reset_preload_busy got %b exp 1", rb1_a); end
    checks++; if (cnt_a !== 6'd1) begin errors++; $display("FAIL reset_preload_count got %0d exp 1", cnt_a); end
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++; if (rd1_a !== 32'h0 || rd1_b !== 32'h0) begin errors++; $display("FAIL reset_async_data got %h/%h exp 0", rd1_a, rd1_b); end
    checks++; if (rb1_a !== 1'b0 || rb1_b !== 1'b0) begin errors++; $display("FAIL reset_async_busy got %b/%b exp 0", rb1_a, rb1_b); end
    checks++; if (cnt_a !== 6'd0 || cnt_b !== 6'd0) begin errors++; $display("FAIL reset_async_count got %0d/%0d exp 0", cnt_a, cnt_b); end
    rst_n = 1'b1;
  endtask

  task automatic test_byte_en();
    do_reset();
    @(posedge clk); #1;
    ReadAddr1 = 5'd5; ReadAddr2 = 5'd7;
    RegWrite = 1'b1; WriteAddr = 5'd5; WriteData = 32'h11223344; WriteByteEn = 4'hF;
    step();
    WriteData = 32'hAABBCCDD; WriteByteEn = 4'b0101;
    @(negedge clk);
    checks++; if (rd1_a !== 32'h11BB33DD) begin errors++; $display("FAIL byte_bypass got %h exp %h", rd1_a, 32'h11BB33DD); end
    checks++; if (rd1_b !== 32'h11223344) begin errors++; $display("FAIL byte_nobypass_old got %h exp %h", rd1_b, 32'h11223344); end
    checks++; if (rd2_a !== 32'h0) begin errors++; $display("FAIL byte_port2_indep got %h exp 0", rd2_a); end
    step();
    idle(); #1;
    checks++; if (rd1_a !== 32'h11BB33DD || rd1_b !== 32'h11BB33DD) begin errors++; $display("FAIL byte_merged got %h/%h exp %h", rd1_a, rd1_b, 32'h11BB33DD); end
  endtask

  task automatic test_bypass();
    do_reset();
    @(posedge clk); #1;
    ReadAddr1 = 5'd7; ReadAddr2 = 5'd7;
    SetBusy = 1'b1; SetBusyAddr = 5'd7;
    step();
    idle();
    RegWrite = 1'b1; WriteAddr = 5'd7; WriteData = 32'h0000CAFE; WriteByteEn = 4'hF;
    @(negedge clk);
    checks++; if (rd1_a !== 32'h0000CAFE || rd2_a !== 32'h0000CAFE) begin errors++; $display("FAIL bypass_data got %h/%h exp %h", rd1_a, rd2_a, 32'h0000CAFE); end
    checks++; if (rd1_b !== 32'h0 || rd2_b !== 32'h0) begin errors++; $display("FAIL nobypass_data got %h/%h exp 0", rd1_b, rd2_b); end
    checks++; if (rb1_a !== 1'b0 || rb2_a !== 1'b0) begin errors++; $display("FAIL bypass_busy_clear got %b/%b exp 0", rb1_a, rb2_a); end
    checks++; if (rb1_b !== 1'b1) begin errors++; $display("FAIL nobypass_busy got %b exp 1", rb1_b); end
    checks++; if (cnt_a !== 6'd1 || cnt_b !== 6'd1) begin errors++; $display("FAIL bypass_count_pre got %0d/%0d exp 1", cnt_a, cnt_b); end
    step();
    idle(); #1;
    checks++; if (rd1_b !== 32'h0000CAFE) begin errors++; $display("FAIL nobypass_after got %h exp %h", rd1_b, 32'h0000CAFE); end
    checks++; if (rb1_a !== 1'b0 || rb1_b !== 1'b0) begin errors++; $display("FAIL bypass_busy_after got %b/%b exp 0", rb1_a, rb1_b); end
    checks++; if (cnt_a !== 6'd0 || cnt_b !== 6'd0) begin errors++; $display("FAIL bypass_count_after got %0d/%0d exp 0", cnt_a, cnt_b); end
  endtask

  task automatic test_zero_reg();
    do_reset();
    @(posedge clk); #1;
    ReadAddr1 = 5'd0; ReadAddr2 = 5'd0;
    RegWrite = 1'b1; WriteAddr = 5'd0; WriteData = 32'hFFFFFFFF; WriteByteEn = 4'hF;
    SetBusy = 1'b1; SetBusyAddr = 5'd0;
    @(negedge clk);
    checks++; if (rd1_a !== 32'h0 || rd1_b !== 32'h0) begin errors++; $display("FAIL zero_pre_data got %h/%h exp 0", rd1_a, rd1_b); end
    step();
    idle(); #1;
    checks++; if (rd1_a !== 32'h0 || rd2_a !== 32'h0) begin errors++; $display("FAIL zero_data got %h/%h exp 0", rd1_a, rd2_a); end
    checks++; if (rb1_a !== 1'b0 || cnt_a !== 6'd0) begin errors++; $display("FAIL zero_busy got %b cnt %0d exp 0 cnt 0", rb1_a, cnt_a); end
    checks++; if (rd1_b !== 32'hFFFFFFFF) begin errors++; $display("FAIL nozero_data got %h exp %h", rd1_b, 32'hFFFFFFFF); end
    checks++; if (rb1_b !== 1'b1 || cnt_b !== 6'd1) begin errors++; $display("FAIL nozero_busy got %b cnt %0d exp 1 cnt 1", rb1_b, cnt_b); end
  endtask

  task automatic test_collision();
    do_reset();
    @(posedge clk); #1;
    ReadAddr1 = 5'd9; ReadAddr2 = 5'd9;
    SetBusy = 1'b1; SetBusyAddr = 5'd9;
    step();
    RegWrite = 1'b1; WriteAddr = 5'd9; WriteData = 32'h12345678; WriteByteEn = 4'hF;
    @(negedge clk);
    checks++; if (rb1_a !== 1'b1 || rb1_b !== 1'b1) begin errors++; $display("FAIL coll_busy_pre got %b/%b exp 1", rb1_a, rb1_b); end
    checks++; if (cnt_a !== 6'd1) begin errors++; $display("FAIL coll_count_pre got %0d exp 1", cnt_a); end
    step();
    idle(); #1;
    checks++; if (rb1_a !== 1'b1 || rb1_b !== 1'b1) begin errors++; $display("FAIL coll_busy_post got %b/%b exp 1", rb1_a, rb1_b); end
    checks++; if (cnt_a !== 6'd1 || cnt_b !== 6'd1) begin errors++; $display("FAIL coll_count_post got %0d/%0d exp 1", cnt_a, cnt_b); end
    RegWrite = 1'b1; WriteAddr = 5'd9; WriteData = 32'h0; WriteByteEn = 4'h0;
    @(negedge clk);
    checks++; if (rb1_a !== 1'b0 || rb1_b !== 1'b1) begin errors++; $display("FAIL lone_busy_pre got %b/%b exp 0/1", rb1_a, rb1_b); end
    step();
    idle(); #1;
    checks++; if (cnt_a !== 6'd0 || cnt_b !== 6'd0) begin errors++; $display("FAIL lone_count got %0d/%0d exp 0", cnt_a, cnt_b); end
    checks++; if (rd1_a !== 32'h12345678) begin errors++; $display("FAIL lone_be0_data got %h exp %h", rd1_a, 32'h12345678); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    @(posedge clk); #1;
    SetBusy = 1'b1; SetBusyAddr = 5'd2;
    step();
    SetBusyAddr = 5'd3;
    step();
    SetBusyAddr = 5'd6;
    RegWrite = 1'b1; WriteAddr = 5'd2; WriteData = 32'h0; WriteByteEn = 4'h0;
    step();
    idle(); #1;
    ReadAddr1 = 5'd2; ReadAddr2 = 5'd6; #1;
    checks++; if (cnt_a !== 6'd2) begin errors++; $display("FAIL b2b_count got %0d exp 2", cnt_a); end
    checks++; if (rb1_a !== 1'b0 || rb2_a !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b/%b exp 0/1", rb1_a, rb2_a); end
  endtask

  task automatic test_saturation();
    do_reset();
    @(posedge clk); #1;
    for (int a = 1; a < 32; a++) begin
      SetBusy = 1'b1; SetBusyAddr = a[4:0];
      step();
    end
    SetBusyAddr = 5'd4;
    step();
    idle(); #1;
    ReadAddr1 = 5'd4; #1;
    checks++; if (cnt_a !== 6'd31 || cnt_b !== 6'd31) begin errors++; $display("FAIL sat_count got %0d/%0d exp 31", cnt_a, cnt_b); end
    checks++; if (rb1_a !== 1'b1) begin errors++; $display("FAIL sat_busy4 got %b exp 1", rb1_a); end
    for (int a = 1; a < 32; a++) begin
      RegWrite = 1'b1; WriteAddr = a[4:0]; WriteData = 32'hFFFFFFFF; WriteByteEn = 4'h0;
      step();
      if (a == 10) begin
        checks++; if (cnt_a !== 6'd21) begin errors++; $display("FAIL clear_mid_count got %0d exp 21", cnt_a); end
      end
    end
    idle(); #1;
    checks++; if (cnt_a !== 6'd0 || cnt_b !== 6'd0) begin errors++; $display("FAIL clear_count got %0d/%0d exp 0", cnt_a, cnt_b); end
    checks++; if (rd1_a !== 32'h0 || rb1_a !== 1'b0) begin errors++; $display("FAIL clear_reg4 got %h busy %b exp 0 busy 0", rd1_a, rb1_a); end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    RegWrite    = 1'b0;
    WriteAddr   = 5'd0;
    WriteData   = 32'h0;
    WriteByteEn = 4'h0;
    ReadAddr1   = 5'd0;
    ReadAddr2   = 5'd0;
    SetBusy     = 1'b0;
    SetBusyAddr = 5'd0;
    #12;
    rst_n = 1'b1;
    test_reset();
    test_byte_en();
    test_bypass();
    test_zero_reg();
    test_collision();
    test_back_to_back();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
